// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Holds the 5-bit opcode encodings, the stage state encoding and small
// opcode-classification helpers used by the top level.
package mem_stage_pkg;

    localparam logic [4:0] OP_LW   = 5'b00000;
    localparam logic [4:0] OP_SW   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_DIV  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_CMP  = 5'b01000;
    localparam logic [4:0] OP_NOT  = 5'b01001;
    localparam logic [4:0] OP_JR   = 5'b01010;
    localparam logic [4:0] OP_JPC  = 5'b01011;
    localparam logic [4:0] OP_BRLF = 5'b01100;
    localparam logic [4:0] OP_CALL = 5'b01101;
    localparam logic [4:0] OP_RET  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESPOND  = 2'd2
    } state_t;

    // Loads and stores are the only opcodes that touch the data bus.
    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Opcodes whose ALU result is written back to the register file.
    function automatic logic writes_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_AND) || (op == OP_OR)  ||
               (op == OP_NOT);
    endfunction

    // Conditional/unconditional jumps that redirect on COND_IN.
    function automatic logic is_cond_jump(input logic [4:0] op);
        return (op == OP_JR) || (op == OP_JPC) || (op == OP_BRLF);
    endfunction

endpackage

// File: rtl/mem_stage_ret_stack.sv
// Return-address stack (LIFO) for CALL/RET.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (to empty)
//   push, pop     - push din / pop top entry; ignored when full / empty
//   din[15:0]     - value to push
//   dout[15:0]    - current top entry (0 when empty)
//   full, empty   - occupancy flags
module ret_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    // Pointer counts entries 0..DEPTH, so it needs one bit more than the index.
    logic [AW:0] ptr_q;
    logic [AW:0] top_idx;

    assign top_idx = ptr_q - (AW+1)'(1);
    assign full    = (ptr_q == (AW+1)'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign dout    = empty ? 16'h0000 : mem[top_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + (AW+1)'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read below the pointer.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage following execute.
// Accepts one packet at a time (READY_OUT high only in IDLE), performs
// LW/SW over a req/ack bus with a timeout, issues PC redirects for jumps,
// CALL and RET (with an internal return-address stack) and presents a
// one-cycle writeback packet in RESPOND.
// Ports:
//   CLK, RST                 - clock, synchronous active-high reset
//   VALID_IN / READY_OUT     - upstream handshake; accept when both high at an edge
//   ALU_IN, OPCD_IN, ADDR_REG_IN, COND_IN, NPC_IN, STORE_DATA_IN - packet fields
//   MEM_REQ/WE/ADDR/WDATA    - data memory request, held for the whole access
//   MEM_RDATA, MEM_ACK       - memory response (single-cycle ack)
//   WB_VALID/EN/ADDR_REG/DATA- writeback packet, valid for one cycle
//   PC_LOAD, PC_TARGET       - one-cycle PC redirect
//   MEM_ERR, STACK_ERR       - sticky error flags, cleared only by reset
// Handshake: a packet transfers on a rising edge where VALID_IN and
// READY_OUT are both 1; the stage then holds READY_OUT low until the
// packet's RESPOND cycle has completed.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    output logic        READY_OUT,
    input  logic [31:0] ALU_IN,
    input  logic [4:0]  OPCD_IN,
    input  logic [4:0]  ADDR_REG_IN,
    input  logic        COND_IN,
    input  logic [15:0] NPC_IN,
    input  logic [15:0] STORE_DATA_IN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        WB_VALID,
    output logic        WB_EN,
    output logic [4:0]  WB_ADDR_REG,
    output logic [15:0] WB_DATA,
    output logic        PC_LOAD,
    output logic [15:0] PC_TARGET,
    output logic        MEM_ERR,
    output logic        STACK_ERR
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [15:0]   alu_q, npc_q, store_q, rdata_q;
    logic [4:0]    opcd_q, addr_reg_q;
    logic          cond_q, mem_ok_q;
    logic [CW-1:0] cnt_q;
    logic          mem_err_q, stack_err_q;

    logic          accept, timeout_hit;
    logic          push, pop, stack_fault;
    logic [15:0]   stack_top;
    logic          stack_full, stack_empty;

    // Only the low half of the ALU result is architecturally used.
    logic          unused_alu_hi;
    assign unused_alu_hi = ^ALU_IN[31:16];

    assign accept = VALID_IN && (state_q == ST_IDLE);
    // An ack in the final counted cycle wins over the timeout.
    assign timeout_hit = (state_q == ST_MEM_WAIT) && !MEM_ACK &&
                         (cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mem_op(OPCD_IN) ? ST_MEM_WAIT : ST_RESPOND;
                end
            end
            ST_MEM_WAIT: begin
                if (MEM_ACK || timeout_hit) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs and stack control
    always_comb begin
        READY_OUT   = (state_q == ST_IDLE);
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = 16'h0000;
        MEM_WDATA   = 16'h0000;
        WB_VALID    = 1'b0;
        WB_EN       = 1'b0;
        WB_ADDR_REG = 5'd0;
        WB_DATA     = 16'h0000;
        PC_LOAD     = 1'b0;
        PC_TARGET   = 16'h0000;
        push        = 1'b0;
        pop         = 1'b0;
        stack_fault = 1'b0;

        if (state_q == ST_MEM_WAIT) begin
            MEM_REQ   = 1'b1;
            MEM_ADDR  = alu_q;
            MEM_WE    = (opcd_q == OP_SW);
            MEM_WDATA = (opcd_q == OP_SW) ? store_q : 16'h0000;
        end

        if (state_q == ST_RESPOND) begin
            WB_VALID    = 1'b1;
            WB_ADDR_REG = addr_reg_q;
            if (writes_alu(opcd_q)) begin
                WB_EN   = 1'b1;
                WB_DATA = alu_q;
            end else if (opcd_q == OP_LW && mem_ok_q) begin
                WB_EN   = 1'b1;
                WB_DATA = rdata_q;
            end else if (is_cond_jump(opcd_q)) begin
                PC_LOAD   = cond_q;
                PC_TARGET = cond_q ? alu_q : 16'h0000;
            end else if (opcd_q == OP_CALL) begin
                if (stack_full) begin
                    stack_fault = 1'b1;
                end else begin
                    push      = 1'b1;
                    PC_LOAD   = 1'b1;
                    PC_TARGET = alu_q;
                end
            end else if (opcd_q == OP_RET) begin
                if (stack_empty) begin
                    stack_fault = 1'b1;
                end else begin
                    pop       = 1'b1;
                    PC_LOAD   = 1'b1;
                    PC_TARGET = stack_top;
                end
            end
        end

        MEM_ERR   = mem_err_q;
        STACK_ERR = stack_err_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            alu_q       <= '0;
            npc_q       <= '0;
            store_q     <= '0;
            rdata_q     <= '0;
            opcd_q      <= '0;
            addr_reg_q  <= '0;
            cond_q      <= 1'b0;
            mem_ok_q    <= 1'b0;
            cnt_q       <= '0;
            mem_err_q   <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_q      <= ALU_IN[15:0];
                npc_q      <= NPC_IN;
                store_q    <= STORE_DATA_IN;
                opcd_q     <= OPCD_IN;
                addr_reg_q <= ADDR_REG_IN;
                cond_q     <= COND_IN;
                mem_ok_q   <= 1'b0;
            end
            // Counter stays 0 outside MEM_WAIT; cleared on every exit.
            if (state_q == ST_MEM_WAIT) begin
                if (MEM_ACK) begin
                    rdata_q  <= MEM_RDATA;
                    mem_ok_q <= 1'b1;
                    cnt_q    <= '0;
                end else if (timeout_hit) begin
                    mem_err_q <= 1'b1;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (stack_fault) begin
                stack_err_q <= 1'b1;
            end
        end
    end

    ret_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .clk  (CLK),
        .rst  (RST),
        .push (push),
        .pop  (pop),
        .din  (npc_q),
        .dout (stack_top),
        .full (stack_full),
        .empty(stack_empty)
    );

endmodule
